// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per cycle,
// valid/ready handshake, optional early completion of divide-by-zero and signed overflow.
module mul_div_unit #(
  parameter int WIDTH        = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [2:0]       OP_MUL   = 3'b000;
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           op_q, op_d;
  logic                 neg_q, neg_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 ready_q, busy_q;

  logic                 signed_a, signed_b, sign_a, sign_b, b_zero, ovf, special;
  logic [WIDTH-1:0]     mag_a, mag_b, special_res, div_val, div_res, calc_res;
  logic [WIDTH:0]       mul_sum, div_trial;
  logic [2*WIDTH-1:0]   mul_next, div_next, step, prod;

  // Operand decode: signedness, magnitudes and the special divide cases.
  always_comb begin
    signed_a    = (op == 3'b000) || (op == 3'b001) || (op == 3'b010) ||
                  (op == 3'b100) || (op == 3'b110);
    signed_b    = (op == 3'b000) || (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    sign_a      = signed_a & a[WIDTH-1];
    sign_b      = signed_b & b[WIDTH-1];
    mag_a       = sign_a ? -a : a;
    mag_b       = sign_b ? -b : b;
    b_zero      = (b == {WIDTH{1'b0}});
    ovf         = op[2] & ~op[0] & (a == MIN_NEG) & (b == {WIDTH{1'b1}});
    special     = op[2] & (b_zero | ovf);
    if (b_zero) begin
      special_res = op[1] ? a : {WIDTH{1'b1}};
    end else begin
      special_res = op[1] ? {WIDTH{1'b0}} : a;
    end
  end

  // One iteration step and the final sign-corrected result it would produce.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    // Restoring divide: remainder stays below the divisor, so the trial fits WIDTH+1 bits.
    div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    if (div_trial[WIDTH]) begin
      div_next = {acc_q[2*WIDTH-2:0], 1'b0};
    end else begin
      div_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
    step     = op_q[2] ? div_next : mul_next;
    prod     = neg_q ? -step : step;
    div_val  = op_q[1] ? step[2*WIDTH-1:WIDTH] : step[WIDTH-1:0];
    div_res  = neg_q ? -div_val : div_val;
    if (op_q[2]) begin
      calc_res = div_res;
    end else if (op_q == OP_MUL) begin
      calc_res = prod[WIDTH-1:0];
    end else begin
      calc_res = prod[2*WIDTH-1:WIDTH];
    end
  end

  // Next-state and datapath register update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (valid) begin
          op_d = op;
          // Divide-by-zero quotient is all-ones regardless of sign.
          if (op[2]) begin
            neg_d  = op[1] ? sign_a : ((sign_a ^ sign_b) & ~b_zero);
            opnd_d = mag_b;
            acc_d  = {{WIDTH{1'b0}}, mag_a};
          end else begin
            neg_d  = sign_a ^ sign_b;
            opnd_d = mag_a;
            acc_d  = {{WIDTH{1'b0}}, mag_b};
          end
          if (FAST_SPECIAL && special) begin
            state_d  = DONE;
            cnt_d    = {CW{1'b0}};
            result_d = special_res;
          end else begin
            state_d = CALC;
            cnt_d   = CNT_LAST;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        acc_d = step;
        if (cnt_q == {CW{1'b0}}) begin
          state_d  = DONE;
          result_d = calc_res;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= {CW{1'b0}};
      op_q     <= 3'b000;
      neg_q    <= 1'b0;
      opnd_q   <= {WIDTH{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      result_q <= {WIDTH{1'b0}};
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      ready_q  <= (state_d == DONE);
      busy_q   <= (state_d != IDLE);
    end
  end

  assign ready  = ready_q;
  assign busy   = busy_q;
  assign result = result_q;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative RV32M multiply/divide unit that replaces the multiply-only `mul` block in the multicycle CPU.
- Executes all eight M-extension operations, selected by func3, one bit per cycle, with a valid/ready handshake matching the CPU's MUL-state protocol.
- Parametrised in datapath width.
- Divide-by-zero and signed-overflow cases can optionally complete early.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- FAST_SPECIAL, 1, when 1 divide-by-zero and signed overflow complete without iterating.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- valid  input  1  request; held high by the CPU while waiting.
- op  input  3  RV32M func3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  input  WIDTH  rs1 operand.
- b  input  WIDTH  rs2 operand.
- ready  output  1  one-cycle pulse; result valid in the same cycle.
- busy  output  1  high in CALC and DONE.
- result  output  WIDTH  selected result; held until the next accept.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state IDLE, ready=0, busy=0, result=0, iteration counter=0.
- Reset mid-operation: the next cycle is IDLE with all outputs at their reset values; the partial result is discarded.
- States: IDLE, CALC, DONE.
- IDLE:
  - valid=1 accepts the request and latches op, |a|, |b| and the result sign.
  - The operation then enters CALC with counter=WIDTH-1.
  - If FAST_SPECIAL=1 and the op is a divide-by-zero or signed-overflow case, it goes directly to DONE instead.
- CALC:
  - One iteration per cycle; counter decrements.
  - Leaves to DONE when counter==0 at the clock edge.
- DONE:
  - ready=1 for exactly one cycle, result valid; then IDLE.
  - If valid is still high in the following IDLE cycle, a new operation is accepted.
- Latency, with valid first high in cycle 0 (IDLE):
  - Normal ops: CALC in cycles 1..WIDTH, ready=1 in cycle WIDTH+1.
  - FAST_SPECIAL cases: ready=1 in cycle 1.
- valid, op, a and b are ignored outside IDLE; dropping valid mid-operation does not abort it.
- Multiply:
  - Unsigned shift-add on magnitudes into a 2*WIDTH product register.
  - Negate the product if the operand signs differ.
  - Signedness: MUL and MULH treat a and b as signed; MULHSU treats a as signed, b as unsigned; MULHU treats both as unsigned.
  - MUL returns product[WIDTH-1:0]; the others return product[2W-1:W].
- Divide:
  - Restoring, magnitude-based.
  - Quotient sign = sign(a) XOR sign(b) for signed ops.
  - Remainder sign = sign(a) for signed ops.
- Divide-by-zero (b==0), with or without FAST_SPECIAL:
  - DIV and DIVU return all-ones.
  - REM and REMU return a.
- Signed overflow (DIV/REM, a = 1 followed by WIDTH-1 zeros, b = all-ones):
  - DIV returns a.
  - REM returns 0.
- The iterative datapath must produce these same values when FAST_SPECIAL=0.
- result updates only on the clock edge entering DONE and is stable otherwise.

Test Plan:
- MUL a=7, b=0xFFFFFFFD, valid held from cycle 0 -> ready=1 only in cycle 33, result=0xFFFFFFEB; busy=1 in cycles 1..33.
- High-half multiplies:
  - MULH 0x80000000*0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- Signed and unsigned divide:
  - DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD.
  - REM 0xFFFFFFF9/2 -> 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
  - REMU 0xFFFFFFF9/2 -> 1.
- Divide-by-zero:
  - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
  - Ready in cycle 1 with FAST_SPECIAL=1, in cycle 33 with FAST_SPECIAL=0.
- Signed overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- rst=1 in cycle 10 of a DIV -> cycle 11 busy=0, ready=0, result=0; a following MULHU completes correctly.
- valid held high through DONE -> second op accepted in cycle 34, ready again in cycle 67.
